// File: rtl/servo_pwm_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : servo_pwm_decoder
//  Purpose  : Receive side of the servo PWM link. Synchronises the PWM line,
//             measures each high pulse in clk cycles, and presents the result
//             through a valid/ack handshake. Flags overrun, width saturation
//             and line-idle timeout.
//  Ports    : I_clk        - system clock
//             I_rst_n      - synchronous active-low reset
//             I_pwm_in     - asynchronous PWM line (synchronised internally)
//             I_ack        - consumer accepts current result (when o_valid=1)
//             o_valid      - result held valid until acked
//             o_high_width - measured high time in clk cycles (saturating)
//             o_duty_code  - min(o_high_width, 7)
//             o_sat        - width counter saturated during reported pulse
//             o_overrun    - sticky: unacked result was overwritten
//             o_timeout    - line idle >= TIMEOUT cycles (level)
//             o_busy       - pulse currently being measured
//  Revision : 1.0 - initial release
// ============================================================================
module servo_pwm_decoder #(
  parameter int CNT_W   = 14,
  parameter int TIMEOUT = 10000
) (
  input  logic             I_clk,
  input  logic             I_rst_n,
  input  logic             I_pwm_in,
  input  logic             I_ack,
  output logic             o_valid,
  output logic [CNT_W-1:0] o_high_width,
  output logic [2:0]       o_duty_code,
  output logic             o_sat,
  output logic             o_overrun,
  output logic             o_timeout,
  output logic             o_busy
);

  localparam logic [CNT_W-1:0] MAX_CNT    = '1;
  localparam logic [CNT_W-1:0] MAX_CNT_M1 = MAX_CNT - CNT_W'(1);
  localparam logic [CNT_W-1:0] TO_CNT     = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_CNT_M1  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CODE_MAX   = CNT_W'(7);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_HIGH  = 2'd2
  } state_t;

  state_t           state;
  logic             s1, s2, s3;
  logic [1:0]       primed;
  logic [CNT_W-1:0] hcnt;
  logic             sat_flag;
  logic [CNT_W-1:0] idle_cnt;

  logic rise, fall, line_edge, idle_hit;

  assign rise      = s2 & ~s3;
  assign fall      = ~s2 & s3;
  assign line_edge = rise | fall;
  // Idle counter is about to reach TIMEOUT on this edge.
  assign idle_hit  = (state != ST_IDLE) && !line_edge && (idle_cnt == TO_CNT_M1);

  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      s1           <= 1'b0;
      s2           <= 1'b0;
      s3           <= 1'b0;
      primed       <= 2'b00;
      state        <= ST_IDLE;
      hcnt         <= '0;
      sat_flag     <= 1'b0;
      idle_cnt     <= '0;
      o_valid      <= 1'b0;
      o_high_width <= '0;
      o_duty_code  <= 3'd0;
      o_sat        <= 1'b0;
      o_overrun    <= 1'b0;
      o_timeout    <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      s1 <= I_pwm_in;
      s2 <= s1;
      s3 <= s2;
      // s2 only reflects a real line sample two edges after reset; until then
      // IDLE must not trust it, otherwise a pulse in progress at reset would
      // look like a fresh rising edge.
      primed <= {primed[0], 1'b1};

      if (o_valid && I_ack) begin
        o_valid   <= 1'b0;
        o_overrun <= 1'b0;
      end

      if (line_edge) begin
        idle_cnt <= '0;
      end else if ((state != ST_IDLE) && (idle_cnt != TO_CNT)) begin
        idle_cnt <= idle_cnt + CNT_W'(1);
      end

      if (rise) begin
        o_timeout <= 1'b0;
      end else if (idle_hit) begin
        o_timeout <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (primed[1] && !s2) begin
            state <= ST_ARMED;
          end
        end

        ST_ARMED: begin
          if (rise) begin
            state    <= ST_HIGH;
            hcnt     <= CNT_W'(1);
            sat_flag <= 1'b0;
            o_busy   <= 1'b1;
          end
        end

        ST_HIGH: begin
          if (fall) begin
            // Publishing overrides any ack-driven clear above; an ack in the
            // same cycle consumed the old result, so that is not an overrun.
            state        <= ST_ARMED;
            o_busy       <= 1'b0;
            o_high_width <= hcnt;
            o_duty_code  <= (hcnt > CODE_MAX) ? 3'd7 : hcnt[2:0];
            o_sat        <= sat_flag;
            o_valid      <= 1'b1;
            if (o_valid && !I_ack) begin
              o_overrun <= 1'b1;
            end
          end else if (idle_hit) begin
            // Line stuck high: abandon the measurement.
            state  <= ST_IDLE;
            o_busy <= 1'b0;
          end else if (hcnt != MAX_CNT) begin
            hcnt <= hcnt + CNT_W'(1);
            if (hcnt == MAX_CNT_M1) begin
              sat_flag <= 1'b1;
            end
          end
        end

        default: begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_servo_pwm_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_servo_pwm_decoder
//  Purpose  : Directed self-checking bench for servo_pwm_decoder, built with
//             CNT_W=4 and TIMEOUT=15 so saturation and timeout are reachable
//             with short pulses.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_servo_pwm_decoder;

  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 15;

  logic             clk;
  logic             rst_n;
  logic             pwm;
  logic             ack;
  logic             valid;
  logic [CNT_W-1:0] high_width;
  logic [2:0]       duty_code;
  logic             sat;
  logic             overrun;
  logic             timeout;
  logic             busy;

  int vectors = 0;
  int errors  = 0;

  servo_pwm_decoder #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .I_clk        (clk),
    .I_rst_n      (rst_n),
    .I_pwm_in     (pwm),
    .I_ack        (ack),
    .o_valid      (valid),
    .o_high_width (high_width),
    .o_duty_code  (duty_code),
    .o_sat        (sat),
    .o_overrun    (overrun),
    .o_timeout    (timeout),
    .o_busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit
  // after the rising edge.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Hold the line high for n sampled edges, then drive it low.
  task automatic pulse(input int n);
    pwm = 1'b1;
    tick(n);
    pwm = 1'b0;
  endtask

  task automatic do_ack;
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    pwm   = 1'b0;
    ack   = 1'b0;
    tick(3);

    // Reset state
    chk("rst_valid",   32'(valid), 0);
    chk("rst_width",   32'(high_width), 0);
    chk("rst_code",    32'(duty_code), 0);
    chk("rst_sat",     32'(sat), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_busy",    32'(busy), 0);
    rst_n = 1'b1;
    tick(4);

    // 1: 5-cycle pulse, valid exactly three edges after the fall
    pulse(5);
    tick(2);
    chk("t1_valid_early", 32'(valid), 0);
    chk("t1_busy_high",   32'(busy), 1);
    tick();
    chk("t1_valid", 32'(valid), 1);
    chk("t1_width", 32'(high_width), 5);
    chk("t1_code",  32'(duty_code), 5);
    chk("t1_sat",   32'(sat), 0);
    chk("t1_busy",  32'(busy), 0);
    do_ack();
    chk("t1_ack_valid", 32'(valid), 0);
    tick(2);

    // 2: 12-cycle pulse, duty code clamps to 7
    pulse(12);
    tick(3);
    chk("t2_valid", 32'(valid), 1);
    chk("t2_width", 32'(high_width), 12);
    chk("t2_code",  32'(duty_code), 7);
    chk("t2_sat",   32'(sat), 0);
    ack = 1'b1;
    chk("t2_valid_hold", 32'(valid), 1);
    tick();
    ack = 1'b0;
    chk("t2_ack_valid", 32'(valid), 0);
    tick(2);

    // 3: two pulses without ack -> overwrite and overrun
    pulse(3);
    tick(3);
    chk("t3_first_width", 32'(high_width), 3);
    pulse(6);
    tick(3);
    chk("t3_valid",   32'(valid), 1);
    chk("t3_width",   32'(high_width), 6);
    chk("t3_code",    32'(duty_code), 6);
    chk("t3_overrun", 32'(overrun), 1);
    do_ack();
    chk("t3_ack_valid",   32'(valid), 0);
    chk("t3_ack_overrun", 32'(overrun), 0);
    tick(2);

    // 4: ack lands on the same edge the second fall is seen
    pulse(3);
    tick(3);
    chk("t4_first_valid", 32'(valid), 1);
    pulse(6);
    tick(2);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("t4_valid",   32'(valid), 1);
    chk("t4_width",   32'(high_width), 6);
    chk("t4_overrun", 32'(overrun), 0);
    do_ack();
    chk("t4_ack_valid", 32'(valid), 0);

    // 5a: 15-cycle pulse reaches the 4-bit ceiling
    pulse(15);
    tick(3);
    chk("t5_valid", 32'(valid), 1);
    chk("t5_width", 32'(high_width), 15);
    chk("t5_code",  32'(duty_code), 7);
    chk("t5_sat",   32'(sat), 1);
    do_ack();

    // 5b: line low -> timeout on the 15th edge after the fall was seen
    tick(13);
    chk("t5_timeout_before", 32'(timeout), 0);
    tick();
    chk("t5_timeout_low", 32'(timeout), 1);

    // 5c: timeout clears when the rise is seen; a stuck-high line then
    // times out in HIGH and the pulse is discarded
    pwm = 1'b1;
    tick(2);
    chk("t5_timeout_hold", 32'(timeout), 1);
    tick();
    chk("t5_timeout_clr", 32'(timeout), 0);
    chk("t5_busy_on",     32'(busy), 1);
    tick(14);
    chk("t5_timeout_high_pre", 32'(timeout), 0);
    chk("t5_busy_pre",         32'(busy), 1);
    tick();
    chk("t5_timeout_high", 32'(timeout), 1);
    chk("t5_busy_drop",    32'(busy), 0);
    pwm = 1'b0;
    tick(5);
    chk("t5_discard_valid", 32'(valid), 0);

    // 6: reset released with the line already high -> partial pulse ignored
    rst_n = 1'b0;
    pwm   = 1'b1;
    tick(2);
    chk("t6_rst_timeout", 32'(timeout), 0);
    chk("t6_rst_busy",    32'(busy), 0);
    rst_n = 1'b1;
    tick(8);
    chk("t6_busy_ignored", 32'(busy), 0);
    pwm = 1'b0;
    tick(5);
    chk("t6_no_valid", 32'(valid), 0);
    pulse(4);
    tick(3);
    chk("t6_valid", 32'(valid), 1);
    chk("t6_width", 32'(high_width), 4);
    chk("t6_code",  32'(duty_code), 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
